// File: rtl/pinwheel_bus_arbiter_pkg.sv
// TileLink-UL channel types and opcodes shared by the pinwheel bus fabric,
// plus the source tags and host FSM states used by the data-bus arbiter.
package pinwheel_bus_arbiter_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic        a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic        d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

    localparam logic SRC_CORE = 1'b0;
    localparam logic SRC_HOST = 1'b1;

    localparam logic [1:0] HOST_IDLE      = 2'd0;
    localparam logic [1:0] HOST_WAIT_RESP = 2'd1;
    localparam logic [1:0] HOST_HOLD_RESP = 2'd2;

endpackage

// File: rtl/pinwheel_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Registered output, one cycle from inc/clear to count.
module pinwheel_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pinwheel_bus_arbiter.sv
// Shares the data-bus slave between the core (absolute priority, never stalls) and a
// valid/ready host port served in core-idle cycles; slave responds 1 cycle after the A beat.
module pinwheel_bus_arbiter
    import pinwheel_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  tilelink_a            core_tla,
    input  logic                 core_rden,
    output tilelink_d            core_tld,
    input  tilelink_a            host_tla,
    output logic                 host_a_ready,
    output tilelink_d            host_tld,
    input  logic                 host_d_ready,
    output tilelink_a            slave_tla,
    input  tilelink_d            slave_tld,
    output logic                 host_starved,
    output logic [CNT_WIDTH-1:0] host_block_cnt
);

    localparam int CONS_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_resp_vld;
    logic              r_resp_src;
    tilelink_d         r_host_resp;
    logic              w_core_req;
    logic              w_host_grant;
    logic              w_host_blocked;
    logic              w_consec_clr;
    logic [CONS_W-1:0] w_consec_cnt;

    // Core Gets that are not real loads are bus filler and must not steal the slot.
    assign w_core_req     = core_tla.a_valid &&
                            ((core_tla.a_opcode == TL_PUT_PARTIAL) || core_rden);
    assign w_host_grant   = (r_state == HOST_IDLE) && host_tla.a_valid && !w_core_req;
    assign w_host_blocked = w_core_req && host_tla.a_valid;
    assign w_consec_clr   = w_host_grant || !host_tla.a_valid;
    assign host_a_ready   = w_host_grant;

    always_comb begin
        slave_tla          = '0;
        slave_tla.a_opcode = TL_GET;
        if (w_core_req) begin
            slave_tla          = core_tla;
            slave_tla.a_source = SRC_CORE;
        end else if (w_host_grant) begin
            slave_tla          = host_tla;
            slave_tla.a_source = SRC_HOST;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOST_IDLE:      if (w_host_grant) w_state_nxt = HOST_WAIT_RESP;
            HOST_WAIT_RESP: w_state_nxt = HOST_HOLD_RESP;
            HOST_HOLD_RESP: if (host_d_ready) w_state_nxt = HOST_IDLE;
            default:        w_state_nxt = HOST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HOST_IDLE;
            r_resp_vld  <= 1'b0;
            r_resp_src  <= SRC_CORE;
            r_host_resp <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_resp_vld <= w_core_req || w_host_grant;
            r_resp_src <= w_host_grant ? SRC_HOST : SRC_CORE;
            if (r_state == HOST_WAIT_RESP) begin
                r_host_resp         <= slave_tld;
                r_host_resp.d_valid <= 1'b1;
            end else if ((r_state == HOST_HOLD_RESP) && host_d_ready) begin
                r_host_resp.d_valid <= 1'b0;
            end
        end
    end

    // Slave data is passed straight through; only the valid is gated by the issue tag.
    always_comb begin
        core_tld         = slave_tld;
        core_tld.d_valid = slave_tld.d_valid && r_resp_vld && (r_resp_src == SRC_CORE);
    end

    assign host_tld = r_host_resp;

    pinwheel_sat_counter #(.WIDTH(CNT_WIDTH)) u_block_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_host_blocked),
        .i_clr   (1'b0),
        .o_cnt   (host_block_cnt)
    );

    pinwheel_sat_counter #(.WIDTH(CONS_W)) u_consec_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_host_blocked),
        .i_clr   (w_consec_clr),
        .o_cnt   (w_consec_cnt)
    );

    assign host_starved = (w_consec_cnt >= CONS_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_pinwheel_bus_arbiter.sv
// Bench for pinwheel_bus_arbiter: a one-cycle slave model, response scoreboards per port,
// and one task per scenario.
module tb_pinwheel_bus_arbiter;
    import pinwheel_bus_arbiter_pkg::*;

    localparam logic [31:0] KEY = 32'h5EAD_BECF;

    logic        clock;
    logic        reset_n;
    tilelink_a   core_tla;
    logic        core_rden;
    tilelink_d   core_tld;
    tilelink_a   host_tla;
    logic        host_a_ready;
    tilelink_d   host_tld;
    logic        host_d_ready;
    tilelink_a   slave_tla;
    tilelink_d   slave_tld;
    logic        host_starved;
    logic [15:0] host_block_cnt;

    int          n_tests;
    int          n_fail;
    int          exp_blk;
    logic [31:0] exp_core[$];
    logic [31:0] exp_host[$];

    pinwheel_bus_arbiter #(.STARVE_LIMIT(64), .CNT_WIDTH(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .core_tla       (core_tla),
        .core_rden      (core_rden),
        .core_tld       (core_tld),
        .host_tla       (host_tla),
        .host_a_ready   (host_a_ready),
        .host_tld       (host_tld),
        .host_d_ready   (host_d_ready),
        .slave_tla      (slave_tla),
        .slave_tld      (slave_tld),
        .host_starved   (host_starved),
        .host_block_cnt (host_block_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: answers every A beat one cycle later with data = address ^ KEY.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slave_tld <= '0;
        end else begin
            slave_tld          <= '0;
            slave_tld.d_valid  <= slave_tla.a_valid;
            slave_tld.d_opcode <= (slave_tla.a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
            slave_tld.d_source <= slave_tla.a_source;
            slave_tld.d_data   <= slave_tla.a_address ^ KEY;
        end
    end

    // Scoreboard side: pop on delivered responses, push host expectations on the A handshake.
    always @(negedge clock) begin
        if (reset_n && core_tld.d_valid) begin
            n_tests++;
            if (exp_core.size() == 0) begin
                n_fail++;
                $display("FAIL core_resp_unexpected data=%h expected none", core_tld.d_data);
            end else begin
                logic [31:0] e;
                e = exp_core.pop_front();
                if (core_tld.d_data !== e) begin
                    n_fail++;
                    $display("FAIL core_resp_data got=%h exp=%h", core_tld.d_data, e);
                end
            end
        end
        if (reset_n && host_tld.d_valid && host_d_ready) begin
            n_tests++;
            if (exp_host.size() == 0) begin
                n_fail++;
                $display("FAIL host_resp_unexpected data=%h expected none", host_tld.d_data);
            end else begin
                logic [31:0] e;
                e = exp_host.pop_front();
                if (host_tld.d_data !== e) begin
                    n_fail++;
                    $display("FAIL host_resp_data got=%h exp=%h", host_tld.d_data, e);
                end
            end
        end
        if (reset_n && host_tla.a_valid && host_a_ready)
            exp_host.push_back(host_tla.a_address ^ KEY);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic core_idle();
        core_tla          = '0;
        core_tla.a_valid  = 1'b1;
        core_tla.a_opcode = TL_GET;
        core_rden         = 1'b0;
    endtask

    task automatic drive_core(input logic [2:0] op, input logic [31:0] addr, input logic rden);
        core_tla           = '0;
        core_tla.a_valid   = 1'b1;
        core_tla.a_opcode  = op;
        core_tla.a_address = addr;
        core_tla.a_mask    = 4'hF;
        core_tla.a_data    = ~addr;
        core_rden          = rden;
        if (rden || op == TL_PUT_PARTIAL)
            exp_core.push_back(addr ^ KEY);
    endtask

    task automatic drive_host(input logic [2:0] op, input logic [31:0] addr);
        host_tla           = '0;
        host_tla.a_valid   = 1'b1;
        host_tla.a_opcode  = op;
        host_tla.a_address = addr;
        host_tla.a_mask    = 4'hF;
        host_tla.a_data    = addr + 32'h1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_tests++;
        if (core_tld.d_valid !== 1'b0 || host_tld.d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dvalid core=%b host=%b exp 0/0", core_tld.d_valid, host_tld.d_valid);
        end
        n_tests++;
        if (host_starved !== 1'b0 || host_block_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters starved=%b cnt=%0d exp 0/0", host_starved, host_block_cnt);
        end
        n_tests++;
        if (slave_tla.a_valid !== 1'b0 || slave_tla.a_mask !== 4'h0 || slave_tla.a_opcode !== TL_GET) begin
            n_fail++;
            $display("FAIL reset_slave_idle v=%b mask=%h op=%0d exp 0/0/%0d",
                     slave_tla.a_valid, slave_tla.a_mask, slave_tla.a_opcode, TL_GET);
        end
        step();
    endtask

    task automatic test_core_load();
        drive_core(TL_GET, 32'h8000_0010, 1'b1);
        @(negedge clock);
        n_tests++;
        if (slave_tla.a_valid !== 1'b1 || slave_tla.a_source !== SRC_CORE ||
            slave_tla.a_address !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL core_load_issue v=%b src=%b addr=%h exp 1/0/80000010",
                     slave_tla.a_valid, slave_tla.a_source, slave_tla.a_address);
        end
        step();
        core_idle();
        @(negedge clock);
        n_tests++;
        if (core_tld.d_valid !== 1'b1 || host_tld.d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL core_load_resp core_v=%b host_v=%b exp 1/0", core_tld.d_valid, host_tld.d_valid);
        end
        step();
    endtask

    task automatic test_host_read();
        host_d_ready = 1'b1;
        drive_host(TL_GET, 32'h8000_0020);
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1 || slave_tla.a_source !== SRC_HOST) begin
            n_fail++;
            $display("FAIL host_read_grant ready=%b src=%b exp 1/1", host_a_ready, slave_tla.a_source);
        end
        step();
        host_tla.a_valid = 1'b0;
        step();
        @(negedge clock);
        n_tests++;
        if (host_tld.d_valid !== 1'b1 || host_tld.d_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL host_read_resp v=%b data=%h exp 1/deadbeef", host_tld.d_valid, host_tld.d_data);
        end
        step();
        drive_host(TL_GET, 32'h8000_0024);
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1 || host_tld.d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL host_read_idle ready=%b dv=%b exp 1/0", host_a_ready, host_tld.d_valid);
        end
        step();
        host_tla.a_valid = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_collision();
        drive_core(TL_PUT_PARTIAL, 32'h8000_0040, 1'b0);
        drive_host(TL_GET, 32'h8000_0044);
        @(negedge clock);
        n_tests++;
        if (slave_tla.a_opcode !== TL_PUT_PARTIAL || slave_tla.a_source !== SRC_CORE || host_a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_core_wins op=%0d src=%b ready=%b exp %0d/0/0",
                     slave_tla.a_opcode, slave_tla.a_source, host_a_ready, TL_PUT_PARTIAL);
        end
        step();
        exp_blk++;
        core_idle();
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1 || host_block_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL collision_host_next ready=%b cnt=%0d exp 1/%0d", host_a_ready, host_block_cnt, exp_blk);
        end
        step();
        host_tla.a_valid = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        drive_host(TL_PUT_FULL, 32'h8000_0100);
        step();
        host_tla.a_valid = 1'b0;
        drive_core(TL_GET, 32'h8000_0104, 1'b1);
        step();
        core_idle();
        @(negedge clock);
        n_tests++;
        if (host_tld.d_valid !== 1'b1 || host_tld.d_opcode !== TL_ACCESS_ACK ||
            core_tld.d_valid !== 1'b1 || core_tld.d_opcode !== TL_ACCESS_ACK_DATA) begin
            n_fail++;
            $display("FAIL b2b_separation host=%b/%0d core=%b/%0d exp 1/%0d 1/%0d",
                     host_tld.d_valid, host_tld.d_opcode, core_tld.d_valid, core_tld.d_opcode,
                     TL_ACCESS_ACK, TL_ACCESS_ACK_DATA);
        end
        idle_cycles(3);
    endtask

    task automatic test_backpressure();
        host_d_ready = 1'b0;
        drive_host(TL_GET, 32'h8000_0080);
        step();
        host_tla.a_valid = 1'b0;
        step();
        drive_host(TL_GET, 32'h8000_0084);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_tests++;
            if (host_tld.d_valid !== 1'b1 || host_tld.d_data !== (32'h8000_0080 ^ KEY) || host_a_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc=%0d v=%b data=%h ready=%b exp 1/%h/0",
                         i, host_tld.d_valid, host_tld.d_data, host_a_ready, 32'h8000_0080 ^ KEY);
            end
            step();
        end
        host_d_ready = 1'b1;
        step();
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1 || host_tld.d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release ready=%b dv=%b exp 1/0", host_a_ready, host_tld.d_valid);
        end
        step();
        host_tla.a_valid = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_starvation();
        drive_host(TL_GET, 32'h8000_00C0);
        for (int i = 0; i < 70; i++) begin
            drive_core(TL_GET, 32'h8000_1000 + 32'(i * 4), 1'b1);
            @(negedge clock);
            n_tests++;
            if (host_a_ready !== 1'b0 || host_starved !== (i >= 64) || host_block_cnt !== 16'(exp_blk)) begin
                n_fail++;
                $display("FAIL starve_cycle i=%0d ready=%b starved=%b cnt=%0d exp 0/%b/%0d",
                         i, host_a_ready, host_starved, host_block_cnt, (i >= 64), exp_blk);
            end
            step();
            exp_blk++;
        end
        core_idle();
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1 || host_starved !== 1'b1 || host_block_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL starve_release ready=%b starved=%b cnt=%0d exp 1/1/%0d",
                     host_a_ready, host_starved, host_block_cnt, exp_blk);
        end
        step();
        host_tla.a_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if (host_starved !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_clear starved=%b exp 0", host_starved);
        end
        idle_cycles(4);
    endtask

    task automatic test_reset_mid();
        host_d_ready = 1'b0;
        drive_host(TL_GET, 32'h8000_0200);
        step();
        host_tla.a_valid = 1'b0;
        step();
        step();
        @(negedge clock);
        n_tests++;
        if (host_tld.d_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pending dv=%b exp 1", host_tld.d_valid);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (host_tld.d_valid !== 1'b0 || host_block_cnt !== 16'd0 || host_starved !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async dv=%b cnt=%0d starved=%b exp 0/0/0",
                     host_tld.d_valid, host_block_cnt, host_starved);
        end
        exp_host.delete();
        exp_blk = 0;
        #1;
        reset_n = 1'b1;
        step();
        host_d_ready = 1'b1;
        drive_host(TL_GET, 32'h8000_0204);
        @(negedge clock);
        n_tests++;
        if (host_a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_idle ready=%b exp 1", host_a_ready);
        end
        step();
        host_tla.a_valid = 1'b0;
        idle_cycles(3);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        exp_blk      = 0;
        reset_n      = 1'b0;
        host_tla     = '0;
        host_d_ready = 1'b1;
        core_idle();
        #12;
        reset_n = 1'b1;
        step();
        test_reset();
        test_core_load();
        test_host_read();
        test_collision();
        test_back_to_back();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        n_tests++;
        if (exp_core.size() != 0 || exp_host.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain core_left=%0d host_left=%0d exp 0/0", exp_core.size(), exp_host.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
